// File: rtl/packetmem_axis_reader_if.sv
// Bundle between the packet-memory forwarder port, the reader and the AXI-Stream sink.
//   master : the reader. It drives rd_addr/rd_en/done and TDATA/TVALID/TLAST.
//            It receives ready/len/rd_data from the packet memory and TREADY from downstream.
//   slave  : the environment side. It has the opposite directions.
interface packetmem_axis_reader_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 8
);
    logic                  ready_for_forwarder;
    logic [ADDR_WIDTH:0]   len_to_forwarder;
    logic [ADDR_WIDTH-1:0] forwarder_rd_addr;
    logic                  forwarder_rd_en;
    logic [DATA_WIDTH-1:0] forwarder_rd_data;
    logic                  forwarder_done;
    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TVALID;
    logic                  TLAST;
    logic                  TREADY;

    modport master (
        input  ready_for_forwarder, len_to_forwarder, forwarder_rd_data, TREADY,
        output forwarder_rd_addr, forwarder_rd_en, forwarder_done, TDATA, TVALID, TLAST
    );

    modport slave (
        output ready_for_forwarder, len_to_forwarder, forwarder_rd_data, TREADY,
        input  forwarder_rd_addr, forwarder_rd_en, forwarder_done, TDATA, TVALID, TLAST
    );
endinterface

// File: rtl/packetmem_axis_reader.sv
// Transmit end of the packet path. The block drains one accepted packet from packet memory
// and emits it as an AXI-Stream master. A credit-tracked skid FIFO hides the BRAM read
// latency, so the block runs at 1 beat/cycle under full TREADY and loses no data under stalls.
//   axi_aclk    : clock
//   axi_aresetn : async active-low reset, deasserted synchronously
//   bus         : forwarder read port + AXI-Stream master (packetmem_axis_reader_if.master)
//
// state    | meaning
// S_IDLE   | waiting for ready_for_forwarder; latches len
// S_STREAM | issuing reads while credits exist
// S_DRAIN  | all reads issued; waiting for the TLAST handshake
// S_DONE   | one-cycle forwarder_done pulse; buffer released
module packetmem_axis_reader #(
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 8,
    parameter int PESSIMISTIC = 1
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    packetmem_axis_reader_if.master bus
);
    localparam int RD_LAT = 1 + PESSIMISTIC;
    localparam int DEPTH  = RD_LAT + 2;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH:0]   r_len, r_rd_cnt;
    logic [RD_LAT-1:0]     r_vld, r_lst;
    logic [DATA_WIDTH-1:0] r_mem_d [DEPTH];
    logic [DEPTH-1:0]      r_mem_l;
    logic [PTR_W-1:0]      r_wr_idx, r_rd_idx;
    logic [CNT_W-1:0]      r_count, w_inflight;
    logic                  w_rd_en, w_done, w_last_rd, w_credit;
    logic                  w_push, w_pop, w_tvalid, w_head_l;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CNT_W'(r_vld[i]);
        end
    end

    // A same-cycle pop is not counted as a free slot. This keeps the credit path
    // registered-only and still leaves one spare slot for full-rate streaming.
    assign w_credit  = (r_count + w_inflight) < CNT_W'(DEPTH);
    assign w_last_rd = (r_rd_cnt == r_len - 1'b1);
    assign w_push    = r_vld[RD_LAT-1];
    assign w_tvalid  = (r_count != '0);
    assign w_pop     = w_tvalid & bus.TREADY;
    assign w_head_l  = w_tvalid & r_mem_l[r_rd_idx];

    // state register
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.ready_for_forwarder)
                          w_state_nxt = (bus.len_to_forwarder == '0) ? S_DONE : S_STREAM;
            S_STREAM: if (w_rd_en && w_last_rd) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_pop && w_head_l)    w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // output logic
    always_comb begin
        w_rd_en = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_STREAM: w_rd_en = w_credit;
            S_DONE:   w_done  = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_len    <= '0;
            r_rd_cnt <= '0;
            r_vld    <= '0;
            r_lst    <= '0;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (r_state == S_IDLE && bus.ready_for_forwarder) begin
                r_len    <= bus.len_to_forwarder;
                r_rd_cnt <= '0;
            end else if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end

            // The read-valid pipe mirrors the BRAM latency. Each stage carries the TLAST tag with it.
            r_vld[0] <= w_rd_en;
            r_lst[0] <= w_rd_en & w_last_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_lst[i] <= r_lst[i-1];
            end

            if (w_push) r_wr_idx <= ptr_inc(r_wr_idx);
            if (w_pop)  r_rd_idx <= ptr_inc(r_rd_idx);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // FIFO storage needs no reset. An empty FIFO masks these registers through r_count.
    always_ff @(posedge axi_aclk) begin
        if (w_push) begin
            r_mem_d[r_wr_idx] <= bus.forwarder_rd_data;
            r_mem_l[r_wr_idx] <= r_lst[RD_LAT-1];
        end
    end

    assign bus.forwarder_rd_en   = w_rd_en;
    assign bus.forwarder_rd_addr = r_rd_cnt[ADDR_WIDTH-1:0];
    assign bus.forwarder_done    = w_done;
    assign bus.TVALID            = w_tvalid;
    assign bus.TDATA             = w_tvalid ? r_mem_d[r_rd_idx] : '0;
    assign bus.TLAST             = w_head_l;
endmodule

// File: tb/tb_packetmem_axis_reader.sv
// Self-checking bench for packetmem_axis_reader (PESSIMISTIC=1, 2-cycle BRAM model).
module tb_packetmem_axis_reader;
    localparam int DW = 128;
    localparam int AW = 8;
    localparam int DEPTH = 4;
    localparam int FIRST_VALID = 4;   // edges E0+RD_LAT+1, seen from the driving cycle

    typedef struct {
        int         len;
        logic [7:0] pat;
        int         exp_beats;
        int         exp_first_valid;
        bit         exp_nobubble;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    packetmem_axis_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    packetmem_axis_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PESSIMISTIC(1)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n), .bus(bus));

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // two-stage BRAM read model
    logic [DW-1:0] mem [256];
    logic [DW-1:0] bram_q1;
    always @(posedge clk) begin
        if (bus.forwarder_rd_en) bram_q1 <= mem[bus.forwarder_rd_addr];
        bus.forwarder_rd_data <= bram_q1;
    end

    logic [7:0] pat = 8'hFF;
    initial begin
        int ph;
        ph = 0;
        bus.TREADY = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.TREADY = pat[ph];
            ph = (ph + 1) % 8;
        end
    end

    logic [DW:0] expq [$];
    logic [7:0]  exp_addr;
    int n_reads, n_beats, n_done, total_done;
    int start_cyc, first_rd_cyc, first_valid_cyc, last_beat_cyc, done_cyc;
    bit          prev_stall = 1'b0;
    logic [DW:0] prev_beat;

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int tag, input int a);
        return {32'(tag), 32'(a) ^ 32'hDEADBEEF, 32'(a * 3 + 1), 32'(a)};
    endfunction

    // monitor: samples mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.forwarder_rd_en) begin
                chk_int("rd_addr", int'(bus.forwarder_rd_addr), int'(exp_addr));
                exp_addr++;
                n_reads++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                chk_int("credit_bound", int'((n_reads - n_beats) <= DEPTH), 1);
            end
            if (prev_stall) begin
                chk_int("tvalid_hold", int'(bus.TVALID), 1);
                chk_vec("stall_stable", {bus.TLAST, bus.TDATA}, prev_beat);
            end
            if (bus.TVALID) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus.TREADY) begin
                    if (expq.size() == 0) begin
                        chk_int("extra_beat", 1, 0);
                    end else begin
                        chk_vec("beat", {bus.TLAST, bus.TDATA}, expq.pop_front());
                    end
                    n_beats++;
                    last_beat_cyc = cyc;
                end
            end
            prev_stall = bus.TVALID & ~bus.TREADY;
            prev_beat  = {bus.TLAST, bus.TDATA};
            if (bus.forwarder_done) begin
                n_done++;
                total_done++;
                done_cyc = cyc;
            end
        end
    end

    // call right after a posedge
    task automatic start_packet(input int len, input int tag);
        for (int a = 0; a < 256; a++) mem[a] = word(tag, a);
        for (int i = 0; i < len; i++) expq.push_back({(i == len - 1), word(tag, i)});
        exp_addr = '0;
        n_reads = 0; n_beats = 0; n_done = 0;
        first_rd_cyc = -1; first_valid_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
        start_cyc = cyc;
        bus.len_to_forwarder = (AW + 1)'(len);
        bus.ready_for_forwarder = 1'b1;
    endtask

    // returns just after the edge that ends the done cycle
    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (bus.forwarder_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk_int({name, "_done_timeout"}, int'(ok), 1);
        @(posedge clk); #1;
    endtask

    task automatic check_common(input int len, input int first_valid, input bit nobubble);
        chk_int("beats", n_beats, len);
        chk_int("reads", n_reads, len);
        chk_int("done_pulses", n_done, 1);
        chk_int("queue_left", expq.size(), 0);
        chk_int("first_valid", (first_valid_cyc < 0) ? -1 : first_valid_cyc - start_cyc, first_valid);
        if (len > 0) begin
            chk_int("first_rd_en", first_rd_cyc - start_cyc, 1);
            chk_int("done_after_last", done_cyc - last_beat_cyc, 1);
            if (nobubble) chk_int("no_bubble", last_beat_cyc - first_valid_cyc, len - 1);
        end else begin
            chk_int("done_latency_len0", done_cyc - start_cyc, 1);
        end
    endtask

    vec_t vecs [8];

    initial begin
        int d1, done_before;
        bit ok;
        vecs[0] = '{4,   8'hFF, 4,   FIRST_VALID, 1'b1};
        vecs[1] = '{6,   8'h99, 6,   FIRST_VALID, 1'b0};
        vecs[2] = '{1,   8'hFF, 1,   FIRST_VALID, 1'b1};
        vecs[3] = '{0,   8'hFF, 0,   -1,          1'b0};
        vecs[4] = '{256, 8'hFF, 256, FIRST_VALID, 1'b1};
        vecs[5] = '{7,   8'h01, 7,   FIRST_VALID, 1'b0};
        vecs[6] = '{5,   8'hFE, 5,   FIRST_VALID, 1'b0};
        vecs[7] = '{9,   8'h5A, 9,   FIRST_VALID, 1'b0};
        total_done = 0;
        n_reads = 0; n_beats = 0; n_done = 0;
        bus.ready_for_forwarder = 1'b0;
        bus.len_to_forwarder = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_int("rst_tvalid", int'(bus.TVALID), 0);
        chk_int("rst_tlast", int'(bus.TLAST), 0);
        chk_int("rst_rd_en", int'(bus.forwarder_rd_en), 0);
        chk_int("rst_done", int'(bus.forwarder_done), 0);
        chk_vec("rst_tdata", {1'b0, bus.TDATA}, '0);
        chk_int("rst_rd_addr", int'(bus.forwarder_rd_addr), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            pat = vecs[v].pat;
            @(posedge clk); #1;
            start_packet(vecs[v].len, v + 1);
            wait_done("vec");
            bus.ready_for_forwarder = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            chk_int("vec_beats", n_beats, vecs[v].exp_beats);
            check_common(vecs[v].len, vecs[v].exp_first_valid, vecs[v].exp_nobubble);
        end

        // back-to-back: ready held high across done
        pat = 8'hFF;
        done_before = total_done;
        @(posedge clk); #1;
        start_packet(3, 100);
        wait_done("b2b1");
        d1 = done_cyc;
        chk_int("b2b1_beats", n_beats, 3);
        start_packet(2, 101);
        chk_int("b2b_restart_cycle", start_cyc, d1 + 1);
        wait_done("b2b2");
        bus.ready_for_forwarder = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_common(2, FIRST_VALID, 1'b1);
        chk_int("b2b_total_done", total_done - done_before, 2);

        // reset after 2 of 5 beats
        @(posedge clk); #1;
        start_packet(5, 200);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (n_beats == 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk_int("rst_mid_wait", int'(ok), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.ready_for_forwarder = 1'b0;
        #1;
        chk_int("midrst_tvalid", int'(bus.TVALID), 0);
        chk_int("midrst_tlast", int'(bus.TLAST), 0);
        chk_int("midrst_rd_en", int'(bus.forwarder_rd_en), 0);
        chk_vec("midrst_tdata", {1'b0, bus.TDATA}, '0);
        done_before = total_done;
        expq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_int("midrst_beats", n_beats, 2);
        chk_int("midrst_no_done", total_done, done_before);
        chk_int("midrst_idle_valid", int'(bus.TVALID), 0);

        @(posedge clk); #1;
        start_packet(2, 201);
        wait_done("post_rst");
        bus.ready_for_forwarder = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_common(2, FIRST_VALID, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
